// File: rtl/pacman_pkg.sv
// Shared definitions for the Pac-Man movement scheduler: one-hot direction
// codes and the scheduler FSM state encoding.
package pacman_pkg;

    localparam logic [3:0] DIR_LEFT  = 4'b1000;
    localparam logic [3:0] DIR_RIGHT = 4'b0100;
    localparam logic [3:0] DIR_UP    = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0001;
    localparam logic [3:0] DIR_NONE  = 4'b0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        DECIDE = 2'd2,
        MOVE   = 2'd3
    } state_t;

endpackage

// File: rtl/pacman_move_scheduler_direction_buffer.sv
// direction_buffer: priority-encodes the player buttons (L > R > U > D) and
// remembers the last requested direction until the scheduler consumes it.
module direction_buffer
    import pacman_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       left_button,
    input  logic       right_button,
    input  logic       up_button,
    input  logic       down_button,
    input  logic       consume,
    output logic [3:0] pending
);

    logic [3:0] pressed;

    // One-hot of the highest-priority button currently held, or none.
    always_comb begin
        pressed = DIR_NONE;
        if (left_button)       pressed = DIR_LEFT;
        else if (right_button) pressed = DIR_RIGHT;
        else if (up_button)    pressed = DIR_UP;
        else if (down_button)  pressed = DIR_DOWN;
    end

    // A fresh press always wins over a consume in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pending <= DIR_NONE;
        else if (pressed != DIR_NONE)
            pending <= pressed;
        else if (consume)
            pending <= DIR_NONE;
    end

endmodule

// File: rtl/pacman_move_scheduler.sv
// pacman_move_scheduler: on each move tick, queries maze legality for the
// current tile, resolves the buffered direction, then steps one tile.
// Optional build macro PACMAN_TUNNEL_WRAP_EN makes horizontal moves off
// either maze edge wrap to the opposite edge instead of saturating.
module pacman_move_scheduler
    import pacman_pkg::*;
#(
    parameter int X_W     = 5,
    parameter int Y_W     = 5,
    parameter int MAZE_W  = 28,
    parameter int MAZE_H  = 31,
    parameter int START_X = 13,
    parameter int START_Y = 23
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           move_tick,
    input  logic           left_button,
    input  logic           right_button,
    input  logic           up_button,
    input  logic           down_button,
    output logic           maze_req,
    output logic [X_W-1:0] maze_x,
    output logic [Y_W-1:0] maze_y,
    input  logic           maze_ack,
    input  logic [3:0]     maze_legal,
    output logic [X_W-1:0] pos_x,
    output logic [Y_W-1:0] pos_y,
    output logic [3:0]     curr_direction,
    output logic           move_done,
    output logic           busy,
    output logic           tick_overrun
);

    localparam logic [X_W-1:0] X_MAX = X_W'(MAZE_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(MAZE_H - 1);

    state_t     state;
    logic [3:0] legal_q;
    logic [3:0] pending;
    logic       consume;

    // The pending direction is taken only when the maze allows it.
    assign consume = (state == DECIDE) && ((pending & legal_q) != DIR_NONE);

    direction_buffer u_dir_buf (
        .clk          (clk),
        .reset_n      (reset_n),
        .left_button  (left_button),
        .right_button (right_button),
        .up_button    (up_button),
        .down_button  (down_button),
        .consume      (consume),
        .pending      (pending)
    );

    // Position only changes in MOVE, so it is a stable query address in REQ.
    assign maze_x = pos_x;
    assign maze_y = pos_y;
    assign busy   = (state != IDLE);

    // Scheduler FSM: tick -> lookup handshake -> direction decision -> step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            legal_q        <= DIR_NONE;
            maze_req       <= 1'b0;
            pos_x          <= X_W'(START_X);
            pos_y          <= Y_W'(START_Y);
            curr_direction <= DIR_NONE;
            move_done      <= 1'b0;
            tick_overrun   <= 1'b0;
        end else begin
            move_done <= 1'b0;
            if (move_tick && state != IDLE)
                tick_overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (move_tick) begin
                        maze_req <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (maze_ack) begin
                        legal_q  <= maze_legal;
                        maze_req <= 1'b0;
                        state    <= DECIDE;
                    end
                end
                DECIDE: begin
                    if ((pending & legal_q) != DIR_NONE)
                        curr_direction <= pending;
                    else if ((curr_direction & legal_q) == DIR_NONE)
                        curr_direction <= DIR_NONE;
                    state <= MOVE;
                end
                MOVE: begin
                    case (curr_direction)
                        DIR_LEFT: begin
                            if (pos_x != '0)
                                pos_x <= pos_x - 1'b1;
`ifdef PACMAN_TUNNEL_WRAP_EN
                            else
                                pos_x <= X_MAX;
`endif
                        end
                        DIR_RIGHT: begin
                            if (pos_x != X_MAX)
                                pos_x <= pos_x + 1'b1;
`ifdef PACMAN_TUNNEL_WRAP_EN
                            else
                                pos_x <= '0;
`endif
                        end
                        DIR_UP: begin
                            if (pos_y != '0)
                                pos_y <= pos_y - 1'b1;
                        end
                        DIR_DOWN: begin
                            if (pos_y != Y_MAX)
                                pos_y <= pos_y + 1'b1;
                        end
                        default: ;
                    endcase
                    move_done <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pacman_move_scheduler.sv
// Directed self-checking bench for pacman_move_scheduler. Inputs are driven
// and outputs sampled on the falling clock edge.
module tb_pacman_move_scheduler;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       move_tick = 1'b0;
    logic       left_button = 1'b0;
    logic       right_button = 1'b0;
    logic       up_button = 1'b0;
    logic       down_button = 1'b0;
    logic       maze_req;
    logic [4:0] maze_x;
    logic [4:0] maze_y;
    logic       maze_ack = 1'b0;
    logic [3:0] maze_legal = 4'b0000;
    logic [4:0] pos_x;
    logic [4:0] pos_y;
    logic [3:0] curr_direction;
    logic       move_done;
    logic       busy;
    logic       tick_overrun;

    int total = 0;
    int bad = 0;

    int  lat;
    bit  tmo;
    bit  stable;
    logic [4:0] qx;
    logic [4:0] qy;

    pacman_move_scheduler dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .move_tick      (move_tick),
        .left_button    (left_button),
        .right_button   (right_button),
        .up_button      (up_button),
        .down_button    (down_button),
        .maze_req       (maze_req),
        .maze_x         (maze_x),
        .maze_y         (maze_y),
        .maze_ack       (maze_ack),
        .maze_legal     (maze_legal),
        .pos_x          (pos_x),
        .pos_y          (pos_y),
        .curr_direction (curr_direction),
        .move_done      (move_done),
        .busy           (busy),
        .tick_overrun   (tick_overrun)
    );

    always #5 clk = ~clk;

    // One movement: tick, answer the lookup after ack_wait extra cycles
    // (optionally re-ticking during the wait), and return the cycle count
    // from tick to move_done along with the address seen during REQ.
    task automatic do_step(input logic [3:0] legal, input int ack_wait,
                           input bit tick_in_wait, input bit immediate,
                           output int l, output bit timeout, output bit stab,
                           output logic [4:0] ax, output logic [4:0] ay);
        timeout = 1'b0;
        stab = 1'b1;
        if (!immediate) @(negedge clk);
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        l = 1;
        while (!maze_req && l < 20) begin
            @(negedge clk);
            l++;
        end
        if (!maze_req) timeout = 1'b1;
        ax = maze_x;
        ay = maze_y;
        for (int i = 0; i < ack_wait; i++) begin
            if (tick_in_wait && i == 1) move_tick = 1'b1;
            @(negedge clk);
            move_tick = 1'b0;
            l++;
            if (!maze_req || maze_x !== ax || maze_y !== ay) stab = 1'b0;
        end
        maze_ack = 1'b1;
        maze_legal = legal;
        @(negedge clk);
        maze_ack = 1'b0;
        maze_legal = 4'b0000;
        l++;
        while (!move_done && l < 40) begin
            @(negedge clk);
            l++;
        end
        if (!move_done) timeout = 1'b1;
    endtask

    task automatic test_reset();
        total++;
        if (pos_x !== 5'd13 || pos_y !== 5'd23) begin
            bad++;
            $display("[TB] FAIL reset_pos got=(%0d,%0d) want=(13,23)", pos_x, pos_y);
        end
        total++;
        if (curr_direction !== 4'b0000 || maze_req !== 1'b0 || busy !== 1'b0 ||
            move_done !== 1'b0 || tick_overrun !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl got dir=%b req=%b busy=%b done=%b ovr=%b want 0000/0/0/0/0",
                     curr_direction, maze_req, busy, move_done, tick_overrun);
        end
        @(negedge clk);
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        total++;
        if (maze_req !== 1'b1) begin
            bad++;
            $display("[TB] FAIL req_after_tick got=%b want=1", maze_req);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (maze_req !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL async_reset got req=%b busy=%b want 0/0", maze_req, busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || maze_req !== 1'b0 || pos_x !== 5'd13) begin
            bad++;
            $display("[TB] FAIL post_reset_idle got busy=%b req=%b x=%0d want 0/0/13", busy, maze_req, pos_x);
        end
    endtask

    task automatic test_left_basic();
        left_button = 1'b1;
        do_step(4'b1000, 0, 1'b0, 1'b0, lat, tmo, stable, qx, qy);
        total++;
        if (tmo || lat !== 4) begin
            bad++;
            $display("[TB] FAIL left_latency got=%0d timeout=%b want=4", lat, tmo);
        end
        total++;
        if (qx !== 5'd13 || qy !== 5'd23) begin
            bad++;
            $display("[TB] FAIL left_query got=(%0d,%0d) want=(13,23)", qx, qy);
        end
        total++;
        if (curr_direction !== 4'b1000 || pos_x !== 5'd12 || pos_y !== 5'd23) begin
            bad++;
            $display("[TB] FAIL left_step got dir=%b pos=(%0d,%0d) want 1000 (12,23)",
                     curr_direction, pos_x, pos_y);
        end
        left_button = 1'b0;
        @(negedge clk);
        total++;
        if (move_done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL done_pulse got done=%b busy=%b want 0/0", move_done, busy);
        end
    endtask

    task automatic test_pending_retained();
        @(negedge clk);
        up_button = 1'b1;
        @(negedge clk);
        up_button = 1'b0;
        do_step(4'b1000, 0, 1'b0, 1'b0, lat, tmo, stable, qx, qy);
        total++;
        if (tmo || curr_direction !== 4'b1000 || pos_x !== 5'd11 || pos_y !== 5'd23) begin
            bad++;
            $display("[TB] FAIL keep_curr got dir=%b pos=(%0d,%0d) want 1000 (11,23)",
                     curr_direction, pos_x, pos_y);
        end
        do_step(4'b0010, 0, 1'b0, 1'b0, lat, tmo, stable, qx, qy);
        total++;
        if (tmo || curr_direction !== 4'b0010 || pos_x !== 5'd11 || pos_y !== 5'd22) begin
            bad++;
            $display("[TB] FAIL pending_taken got dir=%b pos=(%0d,%0d) want 0010 (11,22)",
                     curr_direction, pos_x, pos_y);
        end
    endtask

    task automatic test_stop_wall();
        right_button = 1'b1;
        do_step(4'b0101, 0, 1'b0, 1'b0, lat, tmo, stable, qx, qy);
        right_button = 1'b0;
        total++;
        if (tmo || curr_direction !== 4'b0100 || pos_x !== 5'd12) begin
            bad++;
            $display("[TB] FAIL turn_right got dir=%b x=%0d want 0100 12", curr_direction, pos_x);
        end
        do_step(4'b0001, 0, 1'b0, 1'b0, lat, tmo, stable, qx, qy);
        total++;
        if (tmo || lat !== 4 || curr_direction !== 4'b0000 || pos_x !== 5'd12 || pos_y !== 5'd22) begin
            bad++;
            $display("[TB] FAIL wall_stop got lat=%0d dir=%b pos=(%0d,%0d) want 4 0000 (12,22)",
                     lat, curr_direction, pos_x, pos_y);
        end
        do_step(4'b0000, 0, 1'b0, 1'b0, lat, tmo, stable, qx, qy);
        total++;
        if (tmo || curr_direction !== 4'b0000 || pos_x !== 5'd12 || pos_y !== 5'd22) begin
            bad++;
            $display("[TB] FAIL dead_end got dir=%b pos=(%0d,%0d) want 0000 (12,22)",
                     curr_direction, pos_x, pos_y);
        end
    endtask

    task automatic test_saturate_left();
        int n = 0;
        left_button = 1'b1;
        while (pos_x !== 5'd0 && n < 40) begin
            do_step(4'b1000, 0, 1'b0, 1'b0, lat, tmo, stable, qx, qy);
            n++;
        end
        total++;
        if (pos_x !== 5'd0 || n !== 12) begin
            bad++;
            $display("[TB] FAIL reach_x0 got x=%0d steps=%0d want 0 12", pos_x, n);
        end
        do_step(4'b1000, 0, 1'b0, 1'b0, lat, tmo, stable, qx, qy);
        left_button = 1'b0;
`ifdef PACMAN_TUNNEL_WRAP_EN
        total++;
        if (tmo || pos_x !== 5'd27 || curr_direction !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL left_edge got x=%0d dir=%b want 27 1000", pos_x, curr_direction);
        end
`else
        total++;
        if (tmo || pos_x !== 5'd0 || curr_direction !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL left_edge got x=%0d dir=%b want 0 1000", pos_x, curr_direction);
        end
`endif
    endtask

    task automatic test_saturate_up();
        int n = 0;
        up_button = 1'b1;
        while (pos_y !== 5'd0 && n < 40) begin
            do_step(4'b0010, 0, 1'b0, 1'b0, lat, tmo, stable, qx, qy);
            n++;
        end
        do_step(4'b0010, 0, 1'b0, 1'b0, lat, tmo, stable, qx, qy);
        up_button = 1'b0;
        total++;
        if (tmo || n !== 22 || pos_y !== 5'd0 || curr_direction !== 4'b0010) begin
            bad++;
            $display("[TB] FAIL top_edge got y=%0d steps=%0d dir=%b want 0 22 0010", pos_y, n, curr_direction);
        end
    endtask

    task automatic test_back_to_back();
        down_button = 1'b1;
        do_step(4'b0001, 0, 1'b0, 1'b0, lat, tmo, stable, qx, qy);
        do_step(4'b0001, 0, 1'b0, 1'b1, lat, tmo, stable, qx, qy);
        down_button = 1'b0;
        total++;
        if (tmo || lat !== 4 || pos_y !== 5'd2 || curr_direction !== 4'b0001) begin
            bad++;
            $display("[TB] FAIL back_to_back got lat=%0d y=%0d dir=%b want 4 2 0001", lat, pos_y, curr_direction);
        end
        total++;
        if (tick_overrun !== 1'b0) begin
            bad++;
            $display("[TB] FAIL no_overrun got=%b want=0", tick_overrun);
        end
    endtask

    task automatic test_overrun();
        do_step(4'b0001, 3, 1'b1, 1'b0, lat, tmo, stable, qx, qy);
        total++;
        if (!stable || qx !== 5'd0 || qy !== 5'd2) begin
            bad++;
            $display("[TB] FAIL req_stable got stable=%b q=(%0d,%0d) want 1 (0,2)", stable, qx, qy);
        end
        total++;
        if (tmo || lat !== 7 || pos_y !== 5'd3 || tick_overrun !== 1'b1) begin
            bad++;
            $display("[TB] FAIL overrun got lat=%0d y=%0d ovr=%b want 7 3 1", lat, pos_y, tick_overrun);
        end
        repeat (8) @(negedge clk);
        total++;
        if (pos_y !== 5'd3 || busy !== 1'b0 || tick_overrun !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_step got y=%0d busy=%b ovr=%b want 3 0 1", pos_y, busy, tick_overrun);
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (tick_overrun !== 1'b0 || pos_y !== 5'd23) begin
            bad++;
            $display("[TB] FAIL overrun_clear got ovr=%b y=%0d want 0 23", tick_overrun, pos_y);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_left_basic();
        test_pending_retained();
        test_stop_wall();
        test_saturate_left();
        test_saturate_up();
        test_back_to_back();
        test_overrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
